wordle_guess_entry: RTL and testbench

WORDLE_GUESS_ENTRY -- requirements
Module: wordle_guess_entry

---
 rtl/wordle_guess_entry.sv | 116 +++++++++++
 tb/tb_wordle_guess_entry.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/wordle_guess_entry.sv
// wordle_guess_entry: five-letter guess entry with a one-cycle green pass and a five-cycle yellow pass per row
module wordle_guess_entry (
  input  logic        Clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        Ack,
  input  logic        Sel,
  input  logic [4:0]  letter_idx,
  input  logic [24:0] secret,
  output logic [24:0] guess,
  output logic [2:0]  len,
  output logic [2:0]  row_num,
  output logic [9:0]  result,
  output logic        result_valid,
  output logic        q_I,
  output logic        q_Entry,
  output logic        q_Check,
  output logic        q_Done,
  output logic        Win,
  output logic        Lose
);
  typedef enum logic [3:0] {QI = 4'b0001, QENTRY = 4'b0010, QCHECK = 4'b0100, QDONE = 4'b1000} state_t;
  state_t state, nxt;
  logic [24:0] sec;
  logic [4:0] avail, green, cur;
  logic [2:0] cyc, p, hj;
  logic [9:0] green_res;
  logic hit, all_green, sel_let, sel_del, sel_ent;
  assign sel_let = Sel && letter_idx < 5'd26;
  assign sel_del = Sel && letter_idx == 5'd26;
  assign sel_ent = Sel && letter_idx == 5'd27;
  assign all_green = result == 10'b10_10_10_10_10;
  assign p = (cyc >= 3'd1 && cyc <= 3'd5) ? cyc - 3'd1 : 3'd0;
  assign cur = guess[5*p +: 5];
  assign q_I = state == QI;
  assign q_Entry = state == QENTRY;
  assign q_Check = state == QCHECK;
  assign q_Done = state == QDONE;
  // descending scan so the lowest-indexed available secret letter wins
  always_comb begin
    green = '0;
    green_res = '0;
    hit = 1'b0;
    hj = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      green[i] = guess[5*i +: 5] == sec[5*i +: 5];
      green_res[2*i +: 2] = {green[i], 1'b0};
      if (avail[i] && sec[5*i +: 5] == cur) begin
        hit = 1'b1;
        hj = 3'(i);
      end
    end
  end
  always_comb begin
    nxt = state == QI     ? (Start ? QENTRY : QI) :
          state == QENTRY ? ((sel_ent && len == 3'd5) ? QCHECK : QENTRY) :
          state == QCHECK ? (cyc == 3'd5 ? ((all_green || row_num == 3'd5) ? QDONE : QENTRY) : QCHECK) :
          state == QDONE  ? (Ack ? QI : QDONE) : QI;
  end
  always_ff @(posedge Clk) begin
    if (reset) state <= QI;
    else state <= nxt;
  end
  always_ff @(posedge Clk) begin
    if (reset) begin
      sec <= '0;
      guess <= '0;
      len <= '0;
      row_num <= '0;
      result <= '0;
      result_valid <= 1'b0;
      Win <= 1'b0;
      Lose <= 1'b0;
      avail <= '0;
      cyc <= '0;
    end else begin
      result_valid <= state == QCHECK && cyc == 3'd5;
      cyc <= state == QCHECK ? cyc + 3'd1 : 3'd0;
      if (state == QI && Start) begin
        sec <= secret;
        guess <= '0;
        len <= '0;
        row_num <= '0;
        result <= '0;
        Win <= 1'b0;
        Lose <= 1'b0;
      end
      if (state == QENTRY && sel_let && len < 3'd5) begin
        guess[5*len +: 5] <= letter_idx;
        len <= len + 3'd1;
      end
      if (state == QENTRY && sel_del && len != 3'd0) begin
        guess[5*(len - 3'd1) +: 5] <= 5'd0;
        len <= len - 3'd1;
      end
      if (state == QCHECK) begin
        if (cyc == 3'd0) begin
          result <= green_res;
          avail <= ~green;
        end else if (result[2*p +: 2] != 2'b10) begin
          result[2*p +: 2] <= hit ? 2'b01 : 2'b00;
          if (hit) avail[hj] <= 1'b0;
        end
        if (cyc == 3'd5) begin
          if (all_green) Win <= 1'b1;
          else if (row_num == 3'd5) Lose <= 1'b1;
          else begin
            row_num <= row_num + 3'd1;
            guess <= '0;
            len <= '0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_wordle_guess_entry.sv
// tb_wordle_guess_entry: letter-count Wordle model checked every cycle, plus literal scenario checks
module tb_wordle_guess_entry;
  logic Clk = 0, reset = 1, Start = 0, Ack = 0, Sel = 0;
  logic [4:0] letter_idx = 0;
  logic [24:0] secret = 0, guess;
  logic [2:0] len, row_num;
  logic [9:0] result;
  logic result_valid, q_I, q_Entry, q_Check, q_Done, Win, Lose;
  int checks = 0, failures = 0;
  bit armed = 0;
  wordle_guess_entry dut (
    .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .Sel(Sel), .letter_idx(letter_idx),
    .secret(secret), .guess(guess), .len(len), .row_num(row_num), .result(result),
    .result_valid(result_valid), .q_I(q_I), .q_Entry(q_Entry), .q_Check(q_Check),
    .q_Done(q_Done), .Win(Win), .Lose(Lose)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  function automatic logic [24:0] w(input int a, b, c, d, e);
    return {5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction
  // model: game as arrays of letters, scoring by letter counts
  int m_st, m_len, m_row, m_cc;
  int m_s[5], m_g[5];
  logic [9:0] m_res, f;
  logic m_rv, m_win, m_lose;
  function automatic logic [9:0] score(input int s[5], input int g[5]);
    int cnt[32];
    logic [9:0] r = '0;
    foreach (cnt[k]) cnt[k] = 0;
    for (int i = 0; i < 5; i++) if (g[i] == s[i]) r[2*i +: 2] = 2'd2; else cnt[s[i]]++;
    for (int i = 0; i < 5; i++)
      if (g[i] != s[i] && cnt[g[i]] > 0) begin
        r[2*i +: 2] = 2'd1;
        cnt[g[i]]--;
      end
    return r;
  endfunction
  function automatic logic [24:0] pack(input int g[5]);
    return w(g[0], g[1], g[2], g[3], g[4]);
  endfunction
  always @(posedge Clk) begin
    m_rv = 0;
    if (reset) begin
      m_st = 0; m_len = 0; m_row = 0; m_cc = 0; m_res = 0; m_win = 0; m_lose = 0;
      for (int i = 0; i < 5; i++) begin m_s[i] = 0; m_g[i] = 0; end
    end else if (m_st == 0) begin
      if (Start) begin
        for (int i = 0; i < 5; i++) begin m_s[i] = int'(secret[5*i +: 5]); m_g[i] = 0; end
        m_len = 0; m_row = 0; m_res = 0; m_win = 0; m_lose = 0; m_st = 1;
      end
    end else if (m_st == 1) begin
      if (Sel && letter_idx < 26 && m_len < 5) begin m_g[m_len] = int'(letter_idx); m_len++; end
      else if (Sel && letter_idx == 26 && m_len > 0) begin m_len--; m_g[m_len] = 0; end
      else if (Sel && letter_idx == 27 && m_len == 5) begin m_st = 2; m_cc = 0; end
    end else if (m_st == 2) begin
      f = score(m_s, m_g);
      m_cc++;
      for (int i = 0; i < 5; i++) m_res[2*i +: 2] = (f[2*i +: 2] == 2'd2 || i < m_cc - 1) ? f[2*i +: 2] : 2'd0;
      if (m_cc == 6) begin
        m_rv = 1;
        if (f == 10'b10_10_10_10_10) begin m_win = 1; m_st = 3; end
        else if (m_row == 5) begin m_lose = 1; m_st = 3; end
        else begin
          m_row++; m_len = 0; m_st = 1;
          for (int i = 0; i < 5; i++) m_g[i] = 0;
        end
      end
    end else if (Ack) m_st = 0;
  end
  always @(negedge Clk) if (armed) begin
    chk("state", {q_Done, q_Check, q_Entry, q_I}, 32'(1) << m_st);
    chk("guess", guess, pack(m_g));
    chk("len", len, m_len);
    chk("row_num", row_num, m_row);
    chk("result", result, m_res);
    chk("result_valid", result_valid, m_rv);
    chk("Win", Win, m_win);
    chk("Lose", Lose, m_lose);
  end
  task automatic press(input int idx);
    Sel = 1; letter_idx = 5'(idx);
    @(negedge Clk);
    Sel = 0; letter_idx = 0;
  endtask
  task automatic type_word(input logic [24:0] wd);
    for (int i = 0; i < 5; i++) press(int'(wd[5*i +: 5]));
  endtask
  task automatic start_game(input logic [24:0] s);
    Start = 1; secret = s;
    @(negedge Clk);
    Start = 0;
  endtask
  logic [24:0] crane, bad[6];
  int nchk, nrv;
  initial begin
    crane = w(2, 17, 0, 13, 4);
    bad[0] = w(13, 0, 2, 4, 17); bad[1] = w(0, 0, 0, 0, 0); bad[2] = w(4, 4, 17, 8, 4);
    bad[3] = w(17, 17, 17, 17, 17); bad[4] = w(2, 0, 17, 13, 4); bad[5] = w(19, 17, 0, 2, 4);
    repeat (2) @(negedge Clk);
    armed = 1; reset = 0;
    chk("reset_q_I", q_I, 1);
    chk("reset_result", result, 0);
    // scenario 1: exact match
    start_game(crane);
    type_word(crane);
    press(27);
    nchk = 0; nrv = 0;
    for (int k = 0; k < 12; k++) begin
      nchk += int'(q_Check); nrv += int'(result_valid);
      @(negedge Clk);
    end
    chk("s1_check_cycles", nchk, 6);
    chk("s1_rv_pulses", nrv, 1);
    chk("s1_result", result, 10'b10_10_10_10_10);
    chk("s1_win_done", {Win, q_Done}, 2'b11);
    press(5);
    chk("s1_sel_in_done", guess, crane);
    Ack = 1; @(negedge Clk); Ack = 0;
    chk("s1_ack_hold", {q_I, Win}, 2'b11);
    // scenario 2: repeated letters, Start ignored mid-game
    start_game(crane);
    type_word(w(4, 4, 17, 8, 4));
    start_game(w(4, 4, 17, 8, 4));
    press(27);
    repeat (6) @(negedge Clk);
    chk("s2_result", result, 10'b10_00_01_00_00);
    chk("s2_row_len", {row_num, len}, {3'd1, 3'd0});
    chk("s2_entry", q_Entry, 1);
    // scenario 3: deletes and short enter
    press(0); press(1); press(2); press(26); press(26); press(27);
    chk("s3_len", len, 1);
    chk("s3_guess", guess, 0);
    chk("s3_entry", q_Entry, 1);
    // scenario 4: delete at zero, overflow letter, unused keys
    press(26); press(26);
    chk("s4_empty", {guess, len}, 28'd0);
    for (int i = 0; i < 6; i++) press(i);
    press(29);
    chk("s4_len", len, 5);
    chk("s4_guess", guess, w(0, 1, 2, 3, 4));
    // scenario 5: six wrong guesses
    reset = 1; @(negedge Clk); reset = 0;
    start_game(crane);
    for (int r = 0; r < 6; r++) begin
      type_word(bad[r]);
      press(27);
      repeat (6) @(negedge Clk);
    end
    chk("s5_lose", {Lose, Win, q_Done}, 3'b101);
    chk("s5_row", row_num, 5);
    Ack = 1; @(negedge Clk); Ack = 0;
    chk("s5_ack", {q_I, Lose}, 2'b11);
    // scenario 6: reset in the middle of a check
    start_game(crane);
    type_word(bad[4]);
    press(27);
    repeat (3) @(negedge Clk);
    chk("s6_in_check", q_Check, 1);
    reset = 1; @(negedge Clk); reset = 0;
    chk("s6_idle", {q_I, q_Entry, q_Check, q_Done}, 4'b1000);
    chk("s6_cleared", {guess, len, row_num, result, result_valid, Win, Lose}, 0);
    nrv = 0;
    for (int k = 0; k < 8; k++) begin nrv += int'(result_valid); @(negedge Clk); end
    chk("s6_no_rv", nrv, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
